// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Upstream controller for a 4:1 bit mux. Steps select_line through
//   00,01,10,11. Each value is held for DWELL cycles. At the end of each dwell
//   the mux output is sampled, and the 4-bit source word a[3:0] is rebuilt
//   from those samples. Supports one-shot or continuous scanning, abort, and a
//   saturating count of completed scans.
//
// Ports
//   clk          in   1      single clock, rising edge
//   rst          in   1      synchronous active-high reset, highest priority
//   start        in   1      level; begins a scan, sampled in IDLE only
//   cont         in   1      1 = keep scanning; sampled at each scan completion
//   abort        in   1      drop the current scan; sampled every cycle
//   mux_b        in   1      mux output (sel 00->a[3], 01->a[2], 10->a[1], 11->a[0])
//   select_line  out  2      registered mux select
//   sample_word  out  4      last completed scan as a[3:0]
//   valid        out  1      one-cycle pulse: sample_word updated this cycle
//   busy         out  1      high while scanning
//   scan_count   out  CNT_W  completed scans since reset, saturating
//   state_dbg    out  1      FSM state (0 = IDLE, 1 = SCAN)
//
// Output handshake: valid is a single-cycle strobe with no back-pressure.
// sample_word and scan_count change only in the cycle valid is high. They
// hold their values at all other times, so a consumer may capture sample_word
// in any cycle where valid=1.
module mux_scan_sequencer #(
  parameter int DWELL = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  input  logic             mux_b,
  output logic [1:0]       select_line,
  output logic [3:0]       sample_word,
  output logic             valid,
  output logic             busy,
  output logic [CNT_W-1:0] scan_count,
  output logic             state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Dwell counter value at which the current select is sampled.
  localparam logic [3:0] DWELL_LAST = 4'(DWELL - 1);

  state_t           state, state_n;
  logic [3:0]       cnt, cnt_n;
  logic [3:0]       shadow, shadow_n;
  logic [1:0]       sel_n;
  logic [3:0]       word_n;
  logic             valid_n;
  logic             busy_n;
  logic [CNT_W-1:0] count_n;

  assign state_dbg = (state == SCAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      shadow      <= 4'd0;
      select_line <= 2'd0;
      sample_word <= 4'd0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      scan_count  <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      shadow      <= shadow_n;
      select_line <= sel_n;
      sample_word <= word_n;
      valid       <= valid_n;
      busy        <= busy_n;
      scan_count  <= count_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shadow_n = shadow;
    sel_n    = select_line;
    word_n   = sample_word;
    valid_n  = 1'b0;
    busy_n   = busy;
    count_n  = scan_count;

    case (state)
      IDLE: begin
        // abort wins over start when both are high
        if (start && !abort) begin
          state_n  = SCAN;
          cnt_n    = 4'd0;
          shadow_n = 4'd0;
          sel_n    = 2'd0;
          busy_n   = 1'b1;
        end
      end

      SCAN: begin
        if (abort) begin
          // Abort also covers the completion edge: the partial word is dropped.
          state_n  = IDLE;
          cnt_n    = 4'd0;
          shadow_n = 4'd0;
          sel_n    = 2'd0;
          busy_n   = 1'b0;
        end else if (cnt != DWELL_LAST) begin
          cnt_n = cnt + 4'd1;
        end else begin
          cnt_n = 4'd0;
          // sel 00 maps to a[3], so the sample lands at bit 3-select_line
          shadow_n[2'd3 - select_line] = mux_b;
          if (select_line != 2'd3) begin
            sel_n = select_line + 2'd1;
          end else begin
            // The last bit goes straight from mux_b into the word, so the
            // whole word updates on one edge.
            word_n   = {shadow[3:1], mux_b};
            valid_n  = 1'b1;
            sel_n    = 2'd0;
            shadow_n = 4'd0;
            if (scan_count != {CNT_W{1'b1}}) begin
              count_n = scan_count + 1'b1;
            end
            if (!cont) begin
              state_n = IDLE;
              busy_n  = 1'b0;
            end
          end
        end
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
module tb_mux_scan_sequencer;

  localparam int DWELL_A = 2;
  localparam int CNT_A   = 8;
  localparam int DWELL_B = 1;
  localparam int CNT_B   = 8;
  localparam int DWELL_C = 2;
  localparam int CNT_C   = 2;

  if (DWELL_A < 1 || DWELL_A > 15 || DWELL_B < 1 || DWELL_B > 15 ||
      DWELL_C < 1 || DWELL_C > 15) begin : g_bad_dwell
    $error("DWELL parameter outside 1..15");
  end

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // shared stimulus; each instance has its own start
  logic       cont, abort;
  logic       start_a, start_b, start_c;
  logic [3:0] a_word;

  logic [1:0]       sel_a, sel_b, sel_c;
  logic [3:0]       word_a, word_b, word_c;
  logic             valid_a, valid_b, valid_c;
  logic             busy_a, busy_b, busy_c;
  logic [CNT_A-1:0] count_a;
  logic [CNT_B-1:0] count_b;
  logic [CNT_C-1:0] count_c;
  logic             st_a, st_b, st_c;
  logic             mux_a, mux_b_b, mux_c;

  // combinational mux models
  assign mux_a   = a_word[2'd3 - sel_a];
  assign mux_b_b = a_word[2'd3 - sel_b];
  assign mux_c   = a_word[2'd3 - sel_c];

  mux_scan_sequencer #(.DWELL(DWELL_A), .CNT_W(CNT_A)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cont(cont), .abort(abort),
    .mux_b(mux_a), .select_line(sel_a), .sample_word(word_a), .valid(valid_a),
    .busy(busy_a), .scan_count(count_a), .state_dbg(st_a)
  );

  mux_scan_sequencer #(.DWELL(DWELL_B), .CNT_W(CNT_B)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cont(cont), .abort(abort),
    .mux_b(mux_b_b), .select_line(sel_b), .sample_word(word_b), .valid(valid_b),
    .busy(busy_b), .scan_count(count_b), .state_dbg(st_b)
  );

  mux_scan_sequencer #(.DWELL(DWELL_C), .CNT_W(CNT_C)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .cont(cont), .abort(abort),
    .mux_b(mux_c), .select_line(sel_c), .sample_word(word_c), .valid(valid_c),
    .busy(busy_c), .scan_count(count_c), .state_dbg(st_c)
  );

  // ---------------- scoreboard ----------------
  // entry = {valid cycle[15:0], scan_count[7:0], sample_word[3:0]}
  logic [27:0] exp_a[$];
  logic [27:0] exp_b[$];
  logic [27:0] exp_c[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: valid pulse with nothing expected (cycle %0d)", name, cyc);
  endtask

  always @(negedge clk) begin
    logic [27:0] e;
    if (valid_a === 1'b1) begin
      if (exp_a.size() == 0) unexpected("a_valid");
      else begin
        e = exp_a.pop_front();
        check("a_valid_cycle", cyc, 32'(e[27:12]));
        check("a_count", 32'(count_a), 32'(e[11:4]));
        check("a_word", 32'(word_a), 32'(e[3:0]));
      end
    end
    if (valid_b === 1'b1) begin
      if (exp_b.size() == 0) unexpected("b_valid");
      else begin
        e = exp_b.pop_front();
        check("b_valid_cycle", cyc, 32'(e[27:12]));
        check("b_count", 32'(count_b), 32'(e[11:4]));
        check("b_word", 32'(word_b), 32'(e[3:0]));
      end
    end
    if (valid_c === 1'b1) begin
      if (exp_c.size() == 0) unexpected("c_valid");
      else begin
        e = exp_c.pop_front();
        check("c_valid_cycle", cyc, 32'(e[27:12]));
        check("c_count", 32'(count_c), 32'(e[11:4]));
        check("c_word", 32'(word_c), 32'(e[3:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [27:0] ent(input int c, input int n, input logic [3:0] w);
    return {16'(c), 8'(n), w};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int t0;
    rst = 1'b1; cont = 1'b0; abort = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    a_word = 4'b0000;
    tick(2);
    rst = 1'b0;

    // reset state
    check("rst_sel", 32'(sel_a), 0);
    check("rst_word", 32'(word_a), 0);
    check("rst_valid", 32'(valid_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_count", 32'(count_a), 0);
    check("rst_state", 32'(st_a), 0);
    tick(2);

    // 1: one-shot, a=1010
    a_word = 4'b1010;
    t0 = cyc;
    exp_a.push_back(ent(t0 + 9, 1, 4'b1010));
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check("t1_sel", 32'(sel_a), 32'((k - 1) / 2));
      check("t1_busy", 32'(busy_a), 1);
      tick(1);
    end
    check("t1_busy_end", 32'(busy_a), 0);
    check("t1_sel_end", 32'(sel_a), 0);
    check("t1_word", 32'(word_a), 32'h a);
    check("t1_count", 32'(count_a), 1);
    tick(1);
    check("t1_valid_drop", 32'(valid_a), 0);
    tick(2);

    // 2: continuous, a changes during scan 2, cont cleared during scan 3
    cont = 1'b1;
    a_word = 4'b1010;
    t0 = cyc;
    exp_a.push_back(ent(t0 + 9,  2, 4'b1010));
    exp_a.push_back(ent(t0 + 17, 3, 4'b0110));
    exp_a.push_back(ent(t0 + 25, 4, 4'b0110));
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(8);
    check("t2_busy_9", 32'(busy_a), 1);
    a_word = 4'b0110;
    tick(8);
    check("t2_busy_17", 32'(busy_a), 1);
    cont = 1'b0;
    tick(8);
    check("t2_busy_25", 32'(busy_a), 0);
    check("t2_state_25", 32'(st_a), 0);
    tick(2);

    // 3: restore prior word 1010, then abort at edge 5 and at completion edge
    a_word = 4'b1010;
    t0 = cyc;
    exp_a.push_back(ent(t0 + 9, 5, 4'b1010));
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(10);

    a_word = 4'b0101;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t3_busy", 32'(busy_a), 0);
    check("t3_sel", 32'(sel_a), 0);
    check("t3_word", 32'(word_a), 32'h a);
    check("t3_count", 32'(count_a), 5);
    check("t3_valid", 32'(valid_a), 0);
    tick(4);

    a_word = 4'b1111;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(7);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    check("t3c_valid", 32'(valid_a), 0);
    check("t3c_busy", 32'(busy_a), 0);
    check("t3c_word", 32'(word_a), 32'h a);
    check("t3c_count", 32'(count_a), 5);
    tick(3);

    // 4: reset at edge 4 mid-scan, then a clean scan
    a_word = 4'b1100;
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t4_sel", 32'(sel_a), 0);
    check("t4_word", 32'(word_a), 0);
    check("t4_valid", 32'(valid_a), 0);
    check("t4_busy", 32'(busy_a), 0);
    check("t4_count", 32'(count_a), 0);
    tick(2);
    a_word = 4'b0011;
    t0 = cyc;
    exp_a.push_back(ent(t0 + 9, 1, 4'b0011));
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(8);
    check("t4_word_after", 32'(word_a), 32'h3);
    tick(2);

    // 5: DWELL=1, start held through the scan
    a_word = 4'b0001;
    t0 = cyc;
    exp_b.push_back(ent(t0 + 5, 1, 4'b0001));
    start_b = 1'b1;
    tick(1);
    for (int k = 1; k <= 4; k++) begin
      check("t5_sel", 32'(sel_b), 32'(k - 1));
      tick(1);
    end
    start_b = 1'b0;
    check("t5_busy_end", 32'(busy_b), 0);
    check("t5_word", 32'(word_b), 32'h1);
    check("t5_sel_end", 32'(sel_b), 0);
    tick(3);

    // 6: CNT_W=2 saturation over 5 continuous scans
    a_word = 4'b1001;
    cont = 1'b1;
    t0 = cyc;
    exp_c.push_back(ent(t0 + 9,  1, 4'b1001));
    exp_c.push_back(ent(t0 + 17, 2, 4'b1001));
    exp_c.push_back(ent(t0 + 25, 3, 4'b1001));
    exp_c.push_back(ent(t0 + 33, 3, 4'b1001));
    exp_c.push_back(ent(t0 + 41, 3, 4'b1001));
    start_c = 1'b1;
    tick(1);
    start_c = 1'b0;
    tick(32);
    cont = 1'b0;
    tick(8);
    check("t6_busy_end", 32'(busy_c), 0);
    check("t6_count_sat", 32'(count_c), 3);
    tick(1);

    // start and abort together in IDLE
    start_c = 1'b1;
    abort = 1'b1;
    tick(2);
    check("t6_sa_busy", 32'(busy_c), 0);
    check("t6_sa_state", 32'(st_c), 0);
    start_c = 1'b0;
    abort = 1'b0;
    tick(3);

    // every expected completion must have been seen
    check("exp_a_left", 32'(exp_a.size()), 0);
    check("exp_b_left", 32'(exp_b.size()), 0);
    check("exp_c_left", 32'(exp_c.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
